// File: rtl/cr_prefix_detach_ctlr.sv
// Prefix detach controller: strips PFD/PHD TLVs from the user TLV stream,
// forwards all other words unchanged with a fixed 2-cycle latency, recovers
// the prefix number and checks each stripped body length.

package cr_prefix_detach_pkg;

  localparam logic [3:0] TLV_DATA = 4'h1;
  localparam logic [3:0] TLV_PFD  = 4'h6;
  localparam logic [3:0] TLV_PHD  = 4'h7;

  typedef struct packed {
    logic        sot;
    logic        eot;
    logic [3:0]  typen;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } tlvp_if_bus_t;

endpackage

module cr_prefix_detach_ctlr
  import cr_prefix_detach_pkg::*;
#(
  parameter int PFD_BODY_WORDS = 8,
  parameter int PHD_BODY_WORDS = 4,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             usr_ib_empty,
  input  logic             usr_ib_aempty,
  input  tlvp_if_bus_t     usr_ib_tlv,
  output logic             usr_ib_rd,
  input  logic             usr_ob_full,
  input  logic             usr_ob_afull,
  output logic             usr_ob_wr,
  output tlvp_if_bus_t     usr_ob_tlv,
  output logic [5:0]       pdt_prefix_num,
  output logic             pdt_pfd_done,
  output logic             pdt_phd_done,
  output logic             pdt_len_err,
  output logic [CNT_W-1:0] pdt_strip_cnt,
  output logic [CNT_W-1:0] pdt_err_cnt
);

  localparam logic [8:0] PFD_LEN = 9'(PFD_BODY_WORDS);
  localparam logic [8:0] PHD_LEN = 9'(PHD_BODY_WORDS);

  typedef enum logic [1:0] {
    PASS      = 2'd0,
    STRIP_PFD = 2'd1,
    STRIP_PHD = 2'd2
  } state_t;

  state_t       state_reg;
  logic         s0_valid_reg;
  tlvp_if_bus_t s0_word_reg;
  logic [7:0]   body_cnt_reg;
  logic [5:0]   stage_num_reg;
  logic         ob_full_reg;

  // Decode of the stage-0 word against the current state
  logic       is_pfd_sot;
  logic       is_phd_sot;
  logic       in_strip;
  logic       trunc;
  logic       body;
  logic       body_end;
  logic       len_ok;
  logic       handle_new;
  logic       start_pfx;
  logic       single_err;
  logic       fwd;
  logic       done;
  logic [1:0] err_n;
  logic [1:0] strip_n;
  logic [8:0] exp_len;

  // Almost-empty is not needed: the pop decision only looks at empty.
  logic unused_aempty;
  assign unused_aempty = usr_ib_aempty;

  // The afull margin of 2 covers the two words that can be in flight.
  assign usr_ib_rd = ~usr_ib_empty & ~usr_ob_afull & ~rst;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Classify the stage-0 word: forward, start a strip, body word, or truncation
  always_comb begin
    is_pfd_sot = s0_word_reg.sot & (s0_word_reg.typen == TLV_PFD);
    is_phd_sot = s0_word_reg.sot & (s0_word_reg.typen == TLV_PHD);
    in_strip   = (state_reg != PASS);
    exp_len    = (state_reg == STRIP_PFD) ? PFD_LEN : PHD_LEN;

    // A sot while stripping cuts the current prefix TLV short
    trunc      = s0_valid_reg & in_strip & s0_word_reg.sot;
    body       = s0_valid_reg & in_strip & ~s0_word_reg.sot;
    body_end   = body & s0_word_reg.eot;
    len_ok     = (({1'b0, body_cnt_reg} + 9'd1) == exp_len);
    done       = body_end & len_ok;

    // Words treated as if the FSM were in PASS (including after truncation)
    handle_new = s0_valid_reg & (~in_strip | s0_word_reg.sot);
    start_pfx  = handle_new & (is_pfd_sot | is_phd_sot);
    single_err = start_pfx & s0_word_reg.eot;
    fwd        = handle_new & ~(is_pfd_sot | is_phd_sot);

    // Truncation and a same-word one-word prefix TLV are two separate errors
    err_n   = {1'b0, trunc} + {1'b0, single_err} + {1'b0, body_end & ~len_ok};
    strip_n = err_n + {1'b0, done};
  end

  // Stage 0 valid bit: one entry per popped word
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_reg <= 1'b0;
    end else begin
      s0_valid_reg <= usr_ib_rd;
    end
  end

  // Stage 0 data capture; qualified by the valid bit so no reset is needed
  always_ff @(posedge clk) begin
    if (usr_ib_rd) begin
      s0_word_reg <= usr_ib_tlv;
    end
  end

  // Strip FSM with registered outputs, pulses and statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= PASS;
      body_cnt_reg   <= 8'd0;
      stage_num_reg  <= 6'd0;
      usr_ob_wr      <= 1'b0;
      usr_ob_tlv     <= '0;
      pdt_prefix_num <= 6'd0;
      pdt_pfd_done   <= 1'b0;
      pdt_phd_done   <= 1'b0;
      pdt_len_err    <= 1'b0;
      pdt_strip_cnt  <= '0;
      pdt_err_cnt    <= '0;
    end else begin
      usr_ob_wr <= fwd;
      if (fwd) begin
        usr_ob_tlv <= s0_word_reg;
      end

      if (start_pfx) begin
        stage_num_reg <= s0_word_reg.tdata[5:0];
        body_cnt_reg  <= 8'd0;
        if (s0_word_reg.eot) begin
          state_reg <= PASS;
        end else if (is_pfd_sot) begin
          state_reg <= STRIP_PFD;
        end else begin
          state_reg <= STRIP_PHD;
        end
      end else begin
        if (trunc || body_end) begin
          state_reg <= PASS;
        end
        if (body) begin
          body_cnt_reg <= (body_cnt_reg == 8'hFF) ? 8'hFF : body_cnt_reg + 8'd1;
        end
      end

      pdt_pfd_done <= done & (state_reg == STRIP_PFD);
      pdt_phd_done <= done & (state_reg == STRIP_PHD);
      pdt_len_err  <= (err_n != 2'd0);
      if (done) begin
        pdt_prefix_num <= stage_num_reg;
      end

      pdt_strip_cnt <= sat_add(pdt_strip_cnt, strip_n);
      pdt_err_cnt   <= sat_add(pdt_err_cnt, err_n);
    end
  end

  // Remember outbound full for the overflow check
  always_ff @(posedge clk) begin
    if (rst) begin
      ob_full_reg <= 1'b0;
    end else begin
      ob_full_reg <= usr_ob_full;
    end
  end

  ob_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(usr_ob_wr && ob_full_reg));

endmodule

// File: doc/cr_prefix_detach_ctlr.md
Name: cr_prefix_detach_ctlr

Overview:
Prefix detach controller for the prefix engine's TLV stream. It removes PFD (prefix data) and PHD (prefix header) TLVs from the user stream and forwards every other TLV unchanged and in order. It recovers the 6-bit prefix number from each stripped TLV's first word and checks each body length against the configured word count. It sits on the decompress/return path, ahead of any consumer that must not see prefix TLVs.

Parameters:
PFD_BODY_WORDS, 8, number of PFD words following the PFD first word; legal range 1..255
PHD_BODY_WORDS, 4, number of PHD words following the PHD first word; legal range 1..255
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
usr_ib_empty  input  1  inbound FIFO empty
usr_ib_aempty  input  1  inbound FIFO almost empty; unused, present for interface symmetry
usr_ib_tlv  input  tlvp_if_bus_t  inbound word; fields used: sot, eot, typen, tdata
usr_ib_rd  output  1  inbound pop
usr_ob_full  input  1  outbound FIFO full
usr_ob_afull  input  1  outbound FIFO almost full; asserted with at least 2 free entries remaining
usr_ob_wr  output  1  outbound push
usr_ob_tlv  output  tlvp_if_bus_t  outbound word
pdt_prefix_num  output  6  prefix number of the last correctly stripped TLV
pdt_pfd_done  output  1  1-cycle pulse: PFD TLV stripped with correct length
pdt_phd_done  output  1  1-cycle pulse: PHD TLV stripped with correct length
pdt_len_err  output  1  1-cycle pulse: stripped TLV had wrong length or was truncated
pdt_strip_cnt  output  CNT_W  saturating count of stripped TLVs, including errored ones
pdt_err_cnt  output  CNT_W  saturating count of length errors

Behaviour:
- Reset (rst=1 at a clk edge) forces the following, and takes priority over all activity; a TLV in flight is discarded with no pulses:
  - usr_ob_wr=0, usr_ob_tlv=0
  - all pdt_* outputs = 0
  - stage-0 valid = 0
  - FSM = PASS, body counter = 0
- Read rule: usr_ib_rd = ~usr_ib_empty & ~usr_ob_afull & ~rst (combinational).
- Pipeline:
  - Word popped at cycle n is registered into stage 0 with a valid bit at n+1.
  - If the word is forwarded, usr_ob_wr/usr_ob_tlv are registered at n+2.
  - Fixed latency is 2 cycles; an afull margin of 2 guarantees no overflow.
- usr_ob_wr is never asserted while usr_ob_full=1 was sampled on the previous cycle. Any such assertion is a design error, covered by an assertion.
- FSM states: PASS, STRIP_PFD, STRIP_PHD. Actions apply only when stage 0 is valid.
- PASS:
  - sot=1 and typen==PFD: latch tdata[5:0] into a staging register, clear the body counter, drop the word.
    - If eot=1 on the same word: length error.
    - Otherwise go to STRIP_PFD.
  - sot=1 and typen==PHD: same handling, going to STRIP_PHD.
  - Any other word: forward unchanged and stay in PASS.
- STRIP_x:
  - Words with sot=0 are dropped and the body counter increments; the counter is 8 bits and saturates at 255.
  - On eot=1: if counter+1 == x_BODY_WORDS, copy the staging register to pdt_prefix_num and pulse pdt_x_done; otherwise pulse pdt_len_err. Go to PASS.
  - On sot=1 (truncated TLV): pulse pdt_len_err, leave pdt_prefix_num unchanged, then handle this word exactly as in PASS in the same cycle.
- pdt_prefix_num changes only on a done pulse. Errored TLVs never update it.
- Counters:
  - pdt_strip_cnt increments once per stripped TLV, at the done or error pulse.
  - pdt_err_cnt increments with each pdt_len_err.
  - Both saturate at all-ones.
  - A truncation followed by a same-word single-word prefix TLV gives two errors. Both pulses merge into one pdt_len_err cycle, but pdt_err_cnt and pdt_strip_cnt each advance by 2.
- Non-prefix TLVs arriving between stripped TLVs pass with no gaps. Throughput is 1 word/cycle when input is non-empty and the output is not afull.

Test Plan:
- Stream: DATA TLV (3 words), PFD TLV (sot word with tdata[5:0]=0x2A plus 8 body words, eot on last), DATA TLV (2 words) -> exactly 5 usr_ob_wr words, DATA order preserved; pdt_pfd_done pulses once; pdt_prefix_num=0x2A; pdt_strip_cnt=1.
- PHD TLV with tdata[5:0]=0x05 and 3 body words (PHD_BODY_WORDS=4) -> no output words; pdt_len_err pulses once; pdt_err_cnt=1; pdt_prefix_num keeps its previous value.
- PFD TLV truncated after 2 body words, followed immediately by a DATA sot word -> pdt_len_err pulses on the DATA word's stage-0 cycle; DATA is forwarded; FSM ends in PASS.
- usr_ob_afull held at 1 for 10 cycles mid-DATA-TLV -> usr_ib_rd=0 throughout; at most 2 words are written after afull rises; no words lost or duplicated after release.
- rst asserted for one cycle while in STRIP_PFD after 4 body words -> next cycle all outputs are 0; a fresh full PFD TLV then produces pdt_pfd_done with correct pdt_prefix_num.
- Counter saturation with CNT_W=4: 20 valid PFD TLVs -> pdt_strip_cnt holds 15.
